pipeline_hazard_unit: RTL and testbench
=======================================

# pipeline_hazard_unit

Scoreboard-based hazard controller for the 5-stage RISC-V pipeline. It sits beside the ID stage and drives the PC, IF/ID and ID/EX enables and flushes. It resolves three hazards:
- load-use hazards, with a configurable load latency, using per-register countdown counters;
- taken-branch flushes from EX;
- freezes while the EX-stage multi-cycle mul/div unit is busy.

## Interface
Parameters:
- REG_AW, 5: register address width; the scoreboard holds 2**REG_AW entries.
- LOAD_LAT, 1: number of cycles after a load leaves ID during which its rd must not be read in ID. Legal range is 1..7.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- idValid  in  1  ID holds a valid instruction.
- idUsesRs1, idUsesRs2  in  1 each  the ID instruction reads rs1 / rs2.
- idRs1, idRs2  in  REG_AW each  source register addresses in ID.
- idMemRead  in  1  the ID instruction is a load.
- idRd  in  REG_AW  destination register of the ID instruction.
- branchTaken  in  1  a branch or jump resolved taken in EX this cycle.
- mdBusy  in  1  the EX mul/div unit is holding EX this cycle.
- enPc  out  1  PC register write enable.
- enIfId  out  1  IF/ID register write enable.
- enIdEx  out  1  ID/EX register write enable.
- flushIfId  out  1  IF/ID loads a NOP.
- flushIdEx  out  1  ID/EX loads a bubble (control inhibited).
- loadUseStall  out  1  a load-use stall is asserted this cycle.

## Operation
- State: cnt[r] for r = 0..2**REG_AW-1. Each counter is $clog2(LOAD_LAT+1) bits wide; cnt[0] is tied to 0.
- Hazard detection (combinational): hz = idValid && ((idUsesRs1 && idRs1!=0 && cnt[idRs1]!=0) || (idUsesRs2 && idRs2!=0 && cnt[idRs2]!=0)).
- Outputs, evaluated in priority order:
  1. reset: enPc=enIfId=enIdEx=0, flushIfId=flushIdEx=1, loadUseStall=0.
  2. mdBusy: enPc=enIfId=enIdEx=0, flushes=0, loadUseStall=0. The pipeline freezes; branchTaken is ignored and must be re-presented by EX.
  3. branchTaken: enPc=enIfId=enIdEx=1, flushIfId=flushIdEx=1, loadUseStall=0.
  4. hz: enPc=enIfId=0, enIdEx=1, flushIdEx=1, flushIfId=0, loadUseStall=1.
  5. otherwise: enables=1, flushes=0, loadUseStall=0.
- Issue is defined as: issue = idValid && !reset && !mdBusy && !branchTaken && !hz.
- Scoreboard update, each edge:
  - every nonzero counter decrements by 1;
  - if issue && idMemRead && idRd!=0, then cnt[idRd] <= LOAD_LAT;
  - when a set and a decrement hit the same register, the set wins.
- Counters never wrap: they saturate at 0 and are only ever loaded with LOAD_LAT.
- Decrement continues during mdBusy, because loads ahead of EX keep moving.
- A flushed or stalled instruction never sets the scoreboard.

## Timing
- All outputs are combinational from the inputs and the current cnt state; there is zero-cycle latency to the pipeline enables.
- A load issued at edge N makes the dependent ID instruction stall in cycles N+1..N+LOAD_LAT. It issues at edge N+LOAD_LAT+1.
  - With LOAD_LAT=1 this is the classic single-bubble load-use stall.
- Back-to-back loads to the same rd: the second load issues only if it does not read that rd, and it reloads the counter to LOAD_LAT.
- A load whose own rs equals the pending rd stalls like any other consumer.
- Reset mid-stall: every counter is 0 after the reset edge, and the stall drops in the first cycle after reset deasserts.
- branchTaken in the same cycle as hz: the flush wins, and the ID instruction is killed (not stalled) without touching the scoreboard.

## Configuration
- HAZARD_PERF_EN
  - Defined: adds two outputs, perfLoadUse[31:0] and perfFlush[31:0].
    - perfLoadUse counts cycles with loadUseStall=1.
    - perfFlush counts cycles where priority 3 (branch flush) applies.
    - Both counters saturate at 32'hFFFF_FFFF and clear on reset.
  - Undefined: neither port nor counter exists; all other behaviour is identical.

## Test plan
- LOAD_LAT=1: lw x5 issues, then add x6,x5,x7 sits in ID -> exactly 1 cycle with enPc=0, enIfId=0, flushIdEx=1, loadUseStall=1; the add issues on the next edge.
- LOAD_LAT=3: lw x5 issues, then a consumer of x5 -> 3 stall cycles. With one independent instruction in between -> 2 stall cycles.
- lw x0 followed by a consumer of x0; lw x5 followed by an instruction with idUsesRs1=0 and idRs1=5 -> no stall in either case.
- branchTaken=1 while hz=1 -> flushIfId=flushIdEx=1, enPc=1, loadUseStall=0; the killed load does not set cnt.
- mdBusy=1 for 4 cycles with lw x5 in flight (LOAD_LAT=3) -> all enables 0 for those 4 cycles; the consumer then issues with no extra stall because its counter has reached 0.
- Assert reset during a LOAD_LAT=3 stall -> during reset, enables=0 and flushes=1; the first post-reset cycle shows no stall. With HAZARD_PERF_EN, perfLoadUse reads 0.

Source files
------------

// File: rtl/pipeline_hazard_unit_if.sv
// Hazard-control bundle between the ID/EX pipeline control and the hazard unit.
// Optional feature macro: HAZARD_PERF_EN adds the perfLoadUse/perfFlush counters.
interface pipeline_hazard_unit_if #(
  parameter int REG_AW = 5
);
  // ID-stage instruction description
  logic              idValid;
  logic              idUsesRs1;
  logic              idUsesRs2;
  logic [REG_AW-1:0] idRs1;
  logic [REG_AW-1:0] idRs2;
  logic              idMemRead;
  logic [REG_AW-1:0] idRd;
  // EX-stage events
  logic              branchTaken;
  logic              mdBusy;
  // pipeline register controls
  logic              enPc;
  logic              enIfId;
  logic              enIdEx;
  logic              flushIfId;
  logic              flushIdEx;
  logic              loadUseStall;
`ifdef HAZARD_PERF_EN
  logic [31:0]       perfLoadUse;
  logic [31:0]       perfFlush;
`endif

  // pipeline side: describes the instructions, obeys the controls
  modport master (
    output idValid, idUsesRs1, idUsesRs2, idRs1, idRs2, idMemRead, idRd,
    output branchTaken, mdBusy,
`ifdef HAZARD_PERF_EN
    input  perfLoadUse, perfFlush,
`endif
    input  enPc, enIfId, enIdEx, flushIfId, flushIdEx, loadUseStall
  );

  // hazard unit side
  modport slave (
    input  idValid, idUsesRs1, idUsesRs2, idRs1, idRs2, idMemRead, idRd,
    input  branchTaken, mdBusy,
`ifdef HAZARD_PERF_EN
    output perfLoadUse, perfFlush,
`endif
    output enPc, enIfId, enIdEx, flushIfId, flushIdEx, loadUseStall
  );
endinterface

// File: rtl/pipeline_hazard_unit.sv
// Scoreboard hazard controller for the 5-stage pipeline: load-use stalls via
// per-register countdown counters, taken-branch flushes, mul/div freezes.
// Optional feature macro: HAZARD_PERF_EN (stall/flush cycle counters).
module pipeline_hazard_unit #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  pipeline_hazard_unit_if.slave  sb
);
  localparam int NREG = 1 << REG_AW;
  localparam int CW   = $clog2(LOAD_LAT + 1);

  logic [CW-1:0] w_cnt [NREG];
  logic          w_hz;
  logic          w_issue;
  logic          w_set_load;
  logic          w_en_pc, w_en_ifid, w_en_idex;
  logic          w_flush_ifid, w_flush_idex, w_stall;

  // x0 is never written, so its counter is permanently zero
  assign w_cnt[0] = '0;

  // A load only arms the scoreboard when it actually leaves ID
  assign w_set_load = w_issue && sb.idMemRead && (sb.idRd != '0);

  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_sb
      logic [CW-1:0] r_cnt;
      // Countdown per register: a new load reload wins over the decrement
      always_ff @(posedge clk) begin
        if (reset)
          r_cnt <= '0;
        else if (w_set_load && (sb.idRd == REG_AW'(gi)))
          r_cnt <= CW'(LOAD_LAT);
        else if (r_cnt != '0)
          r_cnt <= r_cnt - 1'b1;
      end
      assign w_cnt[gi] = r_cnt;
    end
  endgenerate

  assign w_hz = sb.idValid &&
                ((sb.idUsesRs1 && (sb.idRs1 != '0) && (w_cnt[sb.idRs1] != '0)) ||
                 (sb.idUsesRs2 && (sb.idRs2 != '0) && (w_cnt[sb.idRs2] != '0)));

  assign w_issue = sb.idValid && !reset && !sb.mdBusy && !sb.branchTaken && !w_hz;

  // Prioritised enable/flush decode: reset > freeze > branch flush > load-use > run
  always_comb begin
    w_en_pc      = 1'b1;
    w_en_ifid    = 1'b1;
    w_en_idex    = 1'b1;
    w_flush_ifid = 1'b0;
    w_flush_idex = 1'b0;
    w_stall      = 1'b0;
    if (reset) begin
      w_en_pc      = 1'b0;
      w_en_ifid    = 1'b0;
      w_en_idex    = 1'b0;
      w_flush_ifid = 1'b1;
      w_flush_idex = 1'b1;
    end else if (sb.mdBusy) begin
      // whole pipeline holds; EX re-presents any branch once unfrozen
      w_en_pc   = 1'b0;
      w_en_ifid = 1'b0;
      w_en_idex = 1'b0;
    end else if (sb.branchTaken) begin
      w_flush_ifid = 1'b1;
      w_flush_idex = 1'b1;
    end else if (w_hz) begin
      // hold PC and IF/ID, push a bubble into EX
      w_en_pc      = 1'b0;
      w_en_ifid    = 1'b0;
      w_flush_idex = 1'b1;
      w_stall      = 1'b1;
    end
  end

  assign sb.enPc         = w_en_pc;
  assign sb.enIfId       = w_en_ifid;
  assign sb.enIdEx       = w_en_idex;
  assign sb.flushIfId    = w_flush_ifid;
  assign sb.flushIdEx    = w_flush_idex;
  assign sb.loadUseStall = w_stall;

`ifdef HAZARD_PERF_EN
  logic [31:0] r_perf_load_use;
  logic [31:0] r_perf_flush;
  logic        w_branch_flush;

  assign w_branch_flush = !reset && !sb.mdBusy && sb.branchTaken;

  // Saturating counters of load-use stall cycles and branch-flush cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_load_use <= '0;
      r_perf_flush    <= '0;
    end else begin
      if (w_stall && (r_perf_load_use != 32'hFFFF_FFFF))
        r_perf_load_use <= r_perf_load_use + 32'd1;
      if (w_branch_flush && (r_perf_flush != 32'hFFFF_FFFF))
        r_perf_flush <= r_perf_flush + 32'd1;
    end
  end

  assign sb.perfLoadUse = r_perf_load_use;
  assign sb.perfFlush   = r_perf_flush;
`endif
endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed bench: one DUT with LOAD_LAT=1 and one with LOAD_LAT=3 share the
// same stimulus; each step checks the DUT whose behaviour it targets.
module tb_pipeline_hazard_unit;
  // control word = {enPc, enIfId, enIdEx, flushIfId, flushIdEx, loadUseStall}
  localparam logic [5:0] RUN   = 6'b111000;
  localparam logic [5:0] STALL = 6'b001011;
  localparam logic [5:0] FLUSH = 6'b111110;
  localparam logic [5:0] FRZ   = 6'b000000;
  localparam logic [5:0] RST   = 6'b000110;

  logic       clk;
  logic       reset;
  logic       idValid, idUsesRs1, idUsesRs2, idMemRead, branchTaken, mdBusy;
  logic [4:0] idRs1, idRs2, idRd;
  int         checks;
  int         failures;

  pipeline_hazard_unit_if #(.REG_AW(5)) if1 ();
  pipeline_hazard_unit_if #(.REG_AW(5)) if3 ();

  assign if1.idValid = idValid;     assign if3.idValid = idValid;
  assign if1.idUsesRs1 = idUsesRs1; assign if3.idUsesRs1 = idUsesRs1;
  assign if1.idUsesRs2 = idUsesRs2; assign if3.idUsesRs2 = idUsesRs2;
  assign if1.idRs1 = idRs1;         assign if3.idRs1 = idRs1;
  assign if1.idRs2 = idRs2;         assign if3.idRs2 = idRs2;
  assign if1.idMemRead = idMemRead; assign if3.idMemRead = idMemRead;
  assign if1.idRd = idRd;           assign if3.idRd = idRd;
  assign if1.branchTaken = branchTaken; assign if3.branchTaken = branchTaken;
  assign if1.mdBusy = mdBusy;       assign if3.mdBusy = mdBusy;

  pipeline_hazard_unit #(.REG_AW(5), .LOAD_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .sb(if1.slave));
  pipeline_hazard_unit #(.REG_AW(5), .LOAD_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .sb(if3.slave));

  logic [5:0] o1, o3;
  assign o1 = {if1.enPc, if1.enIfId, if1.enIdEx, if1.flushIfId, if1.flushIdEx, if1.loadUseStall};
  assign o3 = {if3.enPc, if3.enIfId, if3.enIdEx, if3.flushIfId, if3.flushIdEx, if3.loadUseStall};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  // present an instruction in ID (called just after a falling edge)
  task automatic instr(input logic u1, input logic [4:0] rs1, input logic u2,
                       input logic [4:0] rs2, input logic mr, input logic [4:0] rd);
    idValid = 1'b1; idUsesRs1 = u1; idRs1 = rs1; idUsesRs2 = u2; idRs2 = rs2;
    idMemRead = mr; idRd = rd;
  endtask

  // settle, then advance to the next falling edge (one rising edge in between)
  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    idValid = 1'b0; idUsesRs1 = 1'b0; idUsesRs2 = 1'b0; idMemRead = 1'b0;
    idRs1 = '0; idRs2 = '0; idRd = '0; branchTaken = 1'b0; mdBusy = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; branchTaken = 1'b0; mdBusy = 1'b0;
    instr(1'b1, 5'd1, 1'b0, 5'd0, 1'b1, 5'd5);   // load in ID during reset must not arm
    #1 chk("rst1_L1", 32'(o1), 32'(RST));
    chk("rst1_L3", 32'(o3), 32'(RST));
    step();
    #1 chk("rst2_L3", 32'(o3), 32'(RST));
    step();
    reset = 1'b0;
    idle(0);
    #1 chk("post_rst_idle", 32'(o3), 32'(RUN));
`ifdef HAZARD_PERF_EN
    chk("perf_rst_lu", if3.perfLoadUse, 32'd0);
`endif

    // LAT=1: lw x5 then add x6,x5,x7 -> one bubble
    instr(1'b1, 5'd1, 1'b0, 5'd0, 1'b1, 5'd5);
    #1 chk("A_lw_L1", 32'(o1), 32'(RUN));
    step();
    instr(1'b1, 5'd5, 1'b1, 5'd7, 1'b0, 5'd6);
    #1 chk("A_stall_L1", 32'(o1), 32'(STALL));
    step();
    #1 chk("A_issue_L1", 32'(o1), 32'(RUN));
    step();
    idle(4);

    // LAT=3: lw x5 then consumer -> three stalls
    instr(1'b1, 5'd1, 1'b0, 5'd0, 1'b1, 5'd5);
    #1 chk("B_lw_L3", 32'(o3), 32'(RUN));
    step();
    instr(1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 5'd6);
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("B_stall%0d", i), 32'(o3), 32'(STALL));
      step();
    end
    #1 chk("B_issue_L3", 32'(o3), 32'(RUN));
    step();
    idle(4);

    // LAT=3 with one independent instruction in between -> two stalls
    instr(1'b1, 5'd1, 1'b0, 5'd0, 1'b1, 5'd5);
    step();
    instr(1'b1, 5'd1, 1'b1, 5'd2, 1'b0, 5'd8);
    #1 chk("B2_indep", 32'(o3), 32'(RUN));
    step();
    instr(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd6);
    for (int i = 0; i < 2; i++) begin
      #1 chk($sformatf("B2_stall%0d", i), 32'(o3), 32'(STALL));
      step();
    end
    #1 chk("B2_issue", 32'(o3), 32'(RUN));
    step();
    idle(4);

    // x0 never hazards; unused rs field never hazards
    instr(1'b1, 5'd1, 1'b0, 5'd0, 1'b1, 5'd0);
    step();
    instr(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd6);
    #1 chk("C_x0_L3", 32'(o3), 32'(RUN));
    step();
    instr(1'b1, 5'd1, 1'b0, 5'd0, 1'b1, 5'd5);
    step();
    instr(1'b0, 5'd5, 1'b0, 5'd5, 1'b0, 5'd6);
    #1 chk("C_unused_L1", 32'(o1), 32'(RUN));
    chk("C_unused_L3", 32'(o3), 32'(RUN));
    step();
    idle(4);

    // branch while hz: flush wins, killed load (rd=x9) does not arm x9
    instr(1'b1, 5'd1, 1'b0, 5'd0, 1'b1, 5'd5);
    step();
    instr(1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 5'd9);
    branchTaken = 1'b1;
    #1 chk("D_br_hz", 32'(o3), 32'(FLUSH));
    step();
    branchTaken = 1'b0;
    instr(1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd10);
    #1 chk("D_x9_free", 32'(o3), 32'(RUN));
    step();
    // load reading the pending rd stalls like any consumer
    instr(1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 5'd9);
    #1 chk("D_ld_stall", 32'(o3), 32'(STALL));
    step();
    #1 chk("D_ld_issue", 32'(o3), 32'(RUN));
    step();
    // back-to-back load to x9 not reading x9: issues and reloads
    instr(1'b1, 5'd1, 1'b0, 5'd0, 1'b1, 5'd9);
    #1 chk("D_b2b_issue", 32'(o3), 32'(RUN));
    step();
    instr(1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd11);
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("D_reload%0d", i), 32'(o3), 32'(STALL));
      step();
    end
    #1 chk("D_reload_end", 32'(o3), 32'(RUN));
    step();
    idle(4);

    // mul/div freeze for 4 cycles; branch ignored while frozen; counter drains
    instr(1'b1, 5'd1, 1'b0, 5'd0, 1'b1, 5'd5);
    step();
    instr(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd6);
    mdBusy = 1'b1;
    branchTaken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("E_frz%0d", i), 32'(o3), 32'(FRZ));
      step();
      branchTaken = 1'b0;
    end
    mdBusy = 1'b0;
    #1 chk("E_no_stall", 32'(o3), 32'(RUN));
    step();
    idle(4);

    // reset in the middle of a stall
    instr(1'b1, 5'd1, 1'b0, 5'd0, 1'b1, 5'd5);
    step();
    instr(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd6);
    #1 chk("F_stall", 32'(o3), 32'(STALL));
`ifdef HAZARD_PERF_EN
    chk("F_perf_flush", if3.perfFlush, 32'd1);
`endif
    step();
    reset = 1'b1;
    #1 chk("F_rst", 32'(o3), 32'(RST));
    step();
    reset = 1'b0;
    #1 chk("F_post_rst", 32'(o3), 32'(RUN));
`ifdef HAZARD_PERF_EN
    chk("F_perf_lu", if3.perfLoadUse, 32'd0);
    chk("F_perf_fl", if3.perfFlush, 32'd0);
`endif
    step();
    idle(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
